// File: rtl/ps_branch_controller_if.sv
// Bundle between the instruction register/ALU and the branch controller outputs
// that feed the program sequencer.
interface ps_branch_controller_if #(
    parameter int LC_WIDTH = 4
);
    logic [7:0]          ir;
    logic                alu_zero;
    logic                alu_zero_we;
    logic                sync_reset;
    logic                jmp;
    logic                jmp_nz;
    logic                dont_jmp;
    logic [3:0]          jmp_addr;
    logic                zero_flag;
    logic [LC_WIDTH-1:0] loop_count;

    modport master (
        output ir, alu_zero, alu_zero_we,
        input  sync_reset, jmp, jmp_nz, dont_jmp, jmp_addr, zero_flag, loop_count
    );

    modport slave (
        input  ir, alu_zero, alu_zero_we,
        output sync_reset, jmp, jmp_nz, dont_jmp, jmp_addr, zero_flag, loop_count
    );
endinterface

// File: rtl/ps_branch_controller.sv
// Branch decode, zero flag, reset synchronizer, jump shadow tracking and loop counter.
// Optional macro ZERO_FLAG_BYPASS_EN forwards a same-cycle ALU zero write into JNZ.
//
// state     | meaning
// ST_RUN    | normal decode of ir
// ST_SHADOW | cycle after a JMP: ir annulled, held target driven on jmp_addr
module ps_branch_controller #(
    parameter int SYNC_STAGES = 2,
    parameter int LC_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ps_branch_controller_if.slave bus
);
    typedef enum logic {ST_RUN, ST_SHADOW} state_t;

    localparam logic [3:0] OP_LDLC = 4'b1100;
    localparam logic [3:0] OP_DJNZ = 4'b1101;
    localparam logic [3:0] OP_JMP  = 4'b1110;
    localparam logic [3:0] OP_JNZ  = 4'b1111;

    state_t                state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                  sync_reset;
    logic [3:0]            held, held_nxt;
    logic                  zero_flag, zero_flag_nxt;
    logic [LC_WIDTH-1:0]   loop_count, loop_count_nxt;
    logic                  jmp, jmp_nz, dont_jmp;
    logic [3:0]            jmp_addr;
    logic                  zf_for_jnz;

    assign sync_reset = ~sync_ff[SYNC_STAGES-1];

`ifdef ZERO_FLAG_BYPASS_EN
    assign zf_for_jnz = bus.alu_zero_we ? bus.alu_zero : zero_flag;
`else
    assign zf_for_jnz = zero_flag;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff    <= '0;
            state      <= ST_RUN;
            held       <= 4'h0;
            zero_flag  <= 1'b0;
            loop_count <= '0;
        end else begin
            sync_ff    <= {sync_ff[SYNC_STAGES-2:0], 1'b1};
            state      <= state_nxt;
            held       <= held_nxt;
            zero_flag  <= zero_flag_nxt;
            loop_count <= loop_count_nxt;
        end
    end

    always_comb begin
        state_nxt      = ST_RUN;
        held_nxt       = held;
        zero_flag_nxt  = zero_flag;
        loop_count_nxt = loop_count;
        jmp            = 1'b0;
        jmp_nz         = 1'b0;
        dont_jmp       = 1'b0;
        jmp_addr       = 4'h0;
        if (!sync_reset) begin
            if (bus.alu_zero_we)
                zero_flag_nxt = bus.alu_zero;
            if (state == ST_SHADOW) begin
                jmp_addr = held;
            end else begin
                unique case (bus.ir[7:4])
                    OP_JMP: begin
                        jmp       = 1'b1;
                        jmp_addr  = bus.ir[3:0];
                        held_nxt  = bus.ir[3:0];
                        state_nxt = ST_SHADOW;
                    end
                    OP_JNZ: begin
                        jmp_nz   = 1'b1;
                        jmp_addr = bus.ir[3:0];
                        dont_jmp = zf_for_jnz;
                    end
                    OP_LDLC: begin
                        loop_count_nxt = LC_WIDTH'(bus.ir[3:0]);
                    end
                    OP_DJNZ: begin
                        jmp_nz   = 1'b1;
                        jmp_addr = bus.ir[3:0];
                        dont_jmp = (loop_count <= LC_WIDTH'(1));
                        // saturate so a DJNZ at zero just falls through
                        if (loop_count != '0)
                            loop_count_nxt = loop_count - LC_WIDTH'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sync_reset = sync_reset;
    assign bus.jmp        = jmp;
    assign bus.jmp_nz     = jmp_nz;
    assign bus.dont_jmp   = dont_jmp;
    assign bus.jmp_addr   = jmp_addr;
    assign bus.zero_flag  = zero_flag;
    assign bus.loop_count = loop_count;
endmodule

// File: tb/tb_ps_branch_controller.sv
// Scoreboard bench for ps_branch_controller: driver pushes expected outputs, monitor compares.
module tb_ps_branch_controller;
    localparam int SYNC = 2;
    localparam int LCW  = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ps_branch_controller_if #(.LC_WIDTH(LCW)) bus ();

    ps_branch_controller #(.SYNC_STAGES(SYNC), .LC_WIDTH(LCW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct {
        int sync; int jmp; int jnz; int dj; int addr; int zf; int lc;
    } exp_t;

    exp_t q[$];
    int asserts = 0;
    int fails = 0;
    bit done = 1'b0;

    // abstract model: flags and counters as plain integers
    int m_rn = 0, m_ir = 0, m_we = 0, m_z = 0;
    int m_rel = 0, m_zf = 0, m_lc = 0, m_shadow = 0, m_held = 0;

    function automatic exp_t model_out();
        exp_t e;
        int op, a;
        e = '{default: 0};
        e.zf = m_zf;
        e.lc = m_lc;
        e.sync = (m_rn == 0 || m_rel < SYNC) ? 1 : 0;
        op = m_ir / 16;
        a  = m_ir % 16;
        if (e.sync == 0) begin
            if (m_shadow != 0) e.addr = m_held;
            else if (op == 14) begin e.jmp = 1; e.addr = a; end
            else if (op == 15) begin
                e.jnz = 1; e.addr = a; e.dj = m_zf;
`ifdef ZERO_FLAG_BYPASS_EN
                if (m_we != 0) e.dj = m_z;
`endif
            end
            else if (op == 13) begin e.jnz = 1; e.addr = a; e.dj = (m_lc <= 1) ? 1 : 0; end
        end
        return e;
    endfunction

    function automatic void model_edge();
        int op;
        if (m_rn == 0) return;
        if (m_rel >= SYNC) begin
            op = m_ir / 16;
            if (m_we != 0) m_zf = m_z;
            if (m_shadow != 0) m_shadow = 0;
            else if (op == 14) begin m_shadow = 1; m_held = m_ir % 16; end
            else if (op == 12) m_lc = m_ir % 16;
            else if (op == 13) m_lc = (m_lc > 0) ? m_lc - 1 : 0;
        end
        if (m_rel < SYNC) m_rel++;
    endfunction

    function automatic void model_reset();
        m_rel = 0; m_zf = 0; m_lc = 0; m_shadow = 0; m_held = 0;
    endfunction

    task automatic step(input int ir, input int we, input int z, input int rn, input bit pulse);
        @(posedge clk);
        model_edge();
        #1;
        bus.ir = 8'(ir); bus.alu_zero_we = we[0]; bus.alu_zero = z[0];
        m_ir = ir; m_we = we; m_z = z;
        if (pulse) rn = 0;
        reset_n = rn[0];
        m_rn = rn;
        if (rn == 0) model_reset();
        q.push_back(model_out());
        if (pulse) begin
            @(negedge clk);
            #1;
            reset_n = 1'b1;
            m_rn = 1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sync_reset", int'(bus.sync_reset), e.sync);
                chk("jmp",        int'(bus.jmp),        e.jmp);
                chk("jmp_nz",     int'(bus.jmp_nz),     e.jnz);
                chk("dont_jmp",   int'(bus.dont_jmp),   e.dj);
                chk("jmp_addr",   int'(bus.jmp_addr),   e.addr);
                chk("zero_flag",  int'(bus.zero_flag),  e.zf);
                chk("loop_count", int'(bus.loop_count), e.lc);
            end
        end
    end

    initial begin : driver
        int r, ir, rn;
        bus.ir = 8'h00; bus.alu_zero = 1'b0; bus.alu_zero_we = 1'b0;
        // reset held, release, pulse mid-count, then full release
        repeat (3) step(8'h20, 0, 0, 0, 0);
        step(8'h20, 0, 0, 1, 0);
        step(8'h20, 0, 0, 1, 1);
        repeat (3) step(8'h20, 0, 0, 1, 0);
        // JMP with LDLC in its shadow slot, then JMP-in-shadow annulment
        step(8'hC2, 0, 0, 1, 0);
        step(8'hE5, 0, 0, 1, 0);
        step(8'hC7, 0, 0, 1, 0);
        step(8'h20, 0, 0, 1, 0);
        step(8'hE6, 0, 0, 1, 0);
        step(8'hEA, 0, 0, 1, 0);
        step(8'h20, 0, 0, 1, 0);
        // zero flag written then JNZ
        step(8'h20, 1, 1, 1, 0);
        step(8'hF3, 0, 0, 1, 0);
        step(8'h20, 1, 0, 1, 0);
        step(8'hF3, 0, 0, 1, 0);
        // same-cycle write with JNZ
        step(8'hF3, 1, 1, 1, 0);
        step(8'h20, 0, 0, 1, 0);
        step(8'hF3, 1, 0, 1, 0);
        // loop counter
        step(8'hC3, 0, 0, 1, 0);
        repeat (4) step(8'hD8, 0, 0, 1, 0);
        step(8'h20, 0, 0, 1, 0);
        // reset during shadow
        step(8'hE9, 0, 0, 1, 0);
        step(8'h20, 0, 0, 0, 0);
        step(8'h20, 0, 0, 0, 0);
        repeat (3) step(8'h20, 0, 0, 1, 0);
        step(8'hE5, 0, 0, 1, 0);
        step(8'h20, 0, 0, 1, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       ir = 8'hE0 | $urandom_range(0, 15);
            else if (r < 4)  ir = 8'hF0 | $urandom_range(0, 15);
            else if (r < 5)  ir = 8'hC0 | $urandom_range(0, 15);
            else if (r < 8)  ir = 8'hD0 | $urandom_range(0, 15);
            else             ir = $urandom_range(0, 191);
            rn = ($urandom_range(0, 59) == 0) ? 0 : 1;
            step(ir, $urandom_range(0, 1), $urandom_range(0, 1), rn,
                 (rn == 1 && $urandom_range(0, 79) == 0));
        end
        @(negedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
